lifo_stack_hs: RTL
==================

// Module: lifo_stack_hs
// PURPOSE
//   Parametrised single-clock LIFO: next generation of the stack block. Adds
//   single-cycle push/pop with no idle state between operations.
//   Adds simultaneous push+pop (replace top), a registered pop-result valid strobe,
//   a combinational top-of-stack peek, an occupancy count and sticky
//   overflow/underflow error flags. Sits beside the datapath as an operand/
//   return-address store; the producer and consumer share clk.
// PARAMETERS
//   WIDTH  8  data word width in bits (>=1)
//   DEPTH  8  number of entries (>=2, any integer; not limited to powers of 2)
//   CW     localparam = $clog2(DEPTH+1), width of count/high_water
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, ACTIVE-LOW: one clock, reset is synchronous and active-low
//   clr         in   1      synchronous soft clear (empties stack, clears errors)
//   push        in   1      push request, data_in sampled same edge
//   pop         in   1      pop request
//   data_in     in   WIDTH  word to push
//   data_out    out  WIDTH  registered popped word
//   out_valid   out  1      1-cycle strobe: data_out updated by accepted pop
//   top         out  WIDTH  combinational peek: mem[count-1]; 0 when empty
//   count       out  CW     current occupancy, 0..DEPTH
//   full        out  1      count==DEPTH (combinational from count reg)
//   empty       out  1      count==0 (combinational from count reg)
//   ovf_err     out  1      sticky: push rejected while full
//   unf_err     out  1      sticky: pop rejected while empty
//   high_water  out  CW     max count since reset/clr (LIFO_HIGH_WATER_EN only)
// BEHAVIOUR
//   - Priority per edge: rst==0 > clr > push/pop. All updates on posedge clk.
//   - Reset (rst==0): count=0, data_out=0, out_valid=0, ovf_err=0, unf_err=0,
//     high_water=0. mem contents not reset (undefined until written).
//   - clr=1: count=0, ovf_err=unf_err=0, out_valid=0, high_water=0; data_out holds;
//     push/pop same cycle ignored; mem not cleared.
//   - Operation decode (clr=0), out_valid defaults to 0 each cycle:
//     push only, !full : mem[count]<=data_in; count+1.
//     push only,  full : ignored; ovf_err<=1; count unchanged.
//     pop only, !empty : data_out<=mem[count-1]; out_valid<=1; count-1.
//     pop only,  empty : ignored; unf_err<=1; data_out holds.
//     push+pop, !empty : replace: data_out<=old mem[count-1];
//                        mem[count-1]<=data_in; out_valid<=1; count unchanged.
//                        Legal when full (no ovf_err).
//     push+pop,  empty : bypass: data_out<=data_in; out_valid<=1; count stays 0;
//                        no mem write, no unf_err.
//   - Latency: pop result visible on data_out/out_valid 1 cycle after request
//     edge; top reflects a push on the cycle after the push edge.
//   - Back-to-back ops every cycle supported; no busy state, no wait cycles.
//   - Error flags sticky until clr or rst; they never block further operations.
//   - count arithmetic in CW bits; never wraps (guarded by full/empty checks).
// CONFIGURATION
//   LIFO_HIGH_WATER_EN defined: high_water register tracks max(count) after each
//     update (reset/clr to 0); compare uses next-count value.
//   Not defined: high_water port still present, tied to 0; no register inferred.
// TESTING
//   T1 rst low 1 cycle, push 0x11..0x18 (DEPTH=8) -> count=8, full=1, top=0x18;
//      9th push 0x99 -> ovf_err=1, count=8, top=0x18.
//   T2 from T1, 8 pops -> data_out 0x18,0x17..0x11 each with out_valid=1 one
//      cycle after; empty=1; extra pop -> unf_err=1, out_valid=0, data_out=0x11.
//   T3 count=3 top=0x33, push+pop data_in=0xAA -> data_out=0x33, out_valid=1,
//      count=3, top=0xAA; repeat when full -> no ovf_err, count=8.
//   T4 empty, push+pop data_in=0x5C -> data_out=0x5C, out_valid=1, count=0,
//      unf_err=0, top=0.
//   T5 count=5 with ovf_err=1, clr=1 with push=1 -> count=0, ovf_err=0,
//      push not stored; with macro high_water 5 -> 0.
//   T6 rst=0 mid push burst (push held high) -> next edge all outputs at reset
//      values; push ignored that cycle; normal operation on next edge after rst=1.

Source files
------------

// File: rtl/lifo_stack_hs.sv
// -----------------------------------------------------------------------------
// lifo_stack_hs
//   Single-clock LIFO stack used as an operand / return-address store beside
//   the datapath. Accepts one operation per clock with no idle cycles:
//   push, pop, or push+pop together (replace top, or bypass when empty).
//   A popped word is registered onto data_out with a one-cycle out_valid
//   strobe. The current top of stack is visible combinationally on top.
//   Rejected pushes (full) and rejected pops (empty) set sticky error flags.
//
//   Optional feature macro: LIFO_HIGH_WATER_EN
//     defined     : high_water holds the peak occupancy since reset/clr
//     not defined : high_water is tied to zero and no register exists
//
// Parameters
//   WIDTH       data word width in bits (>=1)
//   DEPTH       number of entries (>=2, need not be a power of two)
//   CW          width of count/high_water, $clog2(DEPTH+1)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   clr         synchronous soft clear: empties stack, clears error flags
//   push        push request, data_in sampled on the same edge
//   pop         pop request
//   data_in     word to push
//   data_out    registered popped word (holds between pops)
//   out_valid   one-cycle strobe: data_out was updated by an accepted pop
//   top         combinational peek of the top entry, 0 when empty
//   count       current occupancy, 0..DEPTH
//   full        count == DEPTH
//   empty       count == 0
//   ovf_err     sticky: a push was rejected because the stack was full
//   unf_err     sticky: a pop was rejected because the stack was empty
//   high_water  peak occupancy since reset/clr (see macro above)
// -----------------------------------------------------------------------------
module lifo_stack_hs #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 8,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             ovf_err,
   output logic             unf_err,
   output logic [CW-1:0]    high_water
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [CW-1:0]    count_q,     count_d;
   logic [WIDTH-1:0] data_out_q,  data_out_d;
   logic             out_valid_q, out_valid_d;
   logic             ovf_err_q,   ovf_err_d;
   logic             unf_err_q,   unf_err_d;

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [AW-1:0]    top_idx;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   // Index of the current top entry; only meaningful when not empty.
   assign top_idx = AW'(count_q - CW'(1));
   assign top     = empty ? '0 : mem_q[top_idx];

   always_comb begin
      // NOTE: every signal gets a default before any branch so that no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      count_d     = count_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      ovf_err_d   = ovf_err_q;
      unf_err_d   = unf_err_q;
      mem_we      = 1'b0;
      mem_waddr   = top_idx;

      if (clr) begin
         count_d   = '0;
         ovf_err_d = 1'b0;
         unf_err_d = 1'b0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (!full) begin
                  mem_we    = 1'b1;
                  mem_waddr = AW'(count_q);
                  count_d   = count_q + CW'(1);
               end else begin
                  ovf_err_d = 1'b1;
               end
            end
            2'b01: begin
               if (!empty) begin
                  data_out_d  = mem_q[top_idx];
                  out_valid_d = 1'b1;
                  count_d     = count_q - CW'(1);
               end else begin
                  unf_err_d = 1'b1;
               end
            end
            2'b11: begin
               out_valid_d = 1'b1;
               if (!empty) begin
                  // Replace: return the old top and overwrite it in place,
                  // so occupancy is unchanged and full is not an error.
                  data_out_d = mem_q[top_idx];
                  mem_we     = 1'b1;
               end else begin
                  // Bypass: the pushed word goes straight out, nothing stored.
                  data_out_d = data_in;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst) begin
         count_q     <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_err_q   <= 1'b0;
         unf_err_q   <= 1'b0;
      end else begin
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         ovf_err_q   <= ovf_err_d;
         unf_err_q   <= unf_err_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; occupancy is tracked
   // by count_q, so stale words are never observed and the array can map to
   // plain RAM/flops without a reset network.
   always_ff @(posedge clk) begin
      if (rst && !clr && mem_we) begin
         mem_q[mem_waddr] <= data_in;
      end
   end

`ifdef LIFO_HIGH_WATER_EN
   logic [CW-1:0] high_water_q, high_water_d;

   // Compare against the next count so the peak is captured on the same edge.
   always_comb begin
      high_water_d = high_water_q;
      if (clr) begin
         high_water_d = '0;
      end else if (count_d > high_water_q) begin
         high_water_d = count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         high_water_q <= '0;
      end else begin
         high_water_q <= high_water_d;
      end
   end

   assign high_water = high_water_q;
`else
   assign high_water = '0;
`endif

   assign count     = count_q;
   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign ovf_err   = ovf_err_q;
   assign unf_err   = unf_err_q;

endmodule
